// File: rtl/ps_axis_cmd_unpacker.sv
// ps_axis_cmd_unpacker: parses PS command headers and packs 32-bit payload beats into tagged 256-bit DAC words.
module ps_axis_cmd_unpacker #(
  parameter int          PS_W    = 32,
  parameter int          OUT_W   = 256,
  parameter int          CH_BITS = 4,
  parameter logic [7:0]  MAGIC   = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PS_W-1:0]    s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  output logic [OUT_W-1:0]   m_axis_tdata,
  output logic [CH_BITS-1:0] m_axis_tdest,
  output logic               m_axis_tlast,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               busy,
  output logic               hdr_err
);
  localparam int BEATS = OUT_W / PS_W;
  localparam int IW    = $clog2(BEATS);
  typedef enum logic [1:0] {IDLE, FILL, SEND} state_t;
  state_t               state_q, state_d;
  logic [OUT_W-1:0]     data_q, data_d;
  logic [CH_BITS-1:0]   ch_q, ch_d;
  logic [15:0]          rem_q, rem_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 err_q, err_d;
  logic                 s_fire, m_fire, hdr_ok;
  assign s_fire = s_axis_tvalid & s_axis_tready;
  assign m_fire = m_axis_tvalid & m_axis_tready;
  assign hdr_ok = (s_axis_tdata[31:24] == MAGIC) && (s_axis_tdata[19:16] == 4'h0) && (s_axis_tdata[15:0] != 16'h0);
  // No input acceptance while a word is waiting downstream, and none while held in reset.
  assign s_axis_tready = !rst && (state_q != SEND);
  assign m_axis_tvalid = state_q == SEND;
  assign m_axis_tlast  = (state_q == SEND) && (rem_q == 16'd1);
  assign m_axis_tdata  = data_q;
  assign m_axis_tdest  = ch_q;
  assign busy          = state_q != IDLE;
  assign hdr_err       = err_q;
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ch_d    = ch_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (s_fire) begin
        if (hdr_ok) begin
          ch_d    = s_axis_tdata[20 +: CH_BITS];
          rem_d   = s_axis_tdata[15:0];
          idx_d   = '0;
          state_d = FILL;
        end else err_d = 1'b1;
      end
      FILL: if (s_fire) begin
        data_d[idx_q*PS_W +: PS_W] = s_axis_tdata;
        idx_d   = idx_q + IW'(1);
        state_d = (idx_q == IW'(BEATS-1)) ? SEND : FILL;
      end
      SEND: if (m_fire) begin
        rem_d   = rem_q - 16'd1;
        idx_d   = '0;
        state_d = (rem_q == 16'd1) ? IDLE : FILL;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      ch_q    <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_ps_axis_cmd_unpacker.sv
// tb_ps_axis_cmd_unpacker: directed scenario tasks for the PS command unpacker.
module tb_ps_axis_cmd_unpacker;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [255:0] m_axis_tdata;
  logic [3:0]   m_axis_tdest;
  logic         m_axis_tlast;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         busy;
  logic         hdr_err;
  int pass_cnt = 0, total_cnt = 0;
  int rd = 0;
  logic tog = 1'b0;
  logic [255:0] wd [0:15];
  logic [3:0]   wdst [0:15];
  logic         wl [0:15];
  int widx = 0, unstable = 0, errs = 0, coinc = 0, overlap = 0, beats = 0, busy_seen = 0;
  logic stall_q = 1'b0;
  logic [255:0] sd;
  logic [3:0] sdst;
  logic sl;

  ps_axis_cmd_unpacker dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tdest(m_axis_tdest), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .busy(busy), .hdr_err(hdr_err)
  );

  always #5 clk = ~clk;

  // Observer on the falling edge: records output handshakes and protocol counters.
  always @(negedge clk) begin
    if (m_axis_tvalid && m_axis_tready && widx < 16) begin
      wd[widx] = m_axis_tdata;
      wdst[widx] = m_axis_tdest;
      wl[widx] = m_axis_tlast;
      widx = widx + 1;
    end
    if (stall_q && (!m_axis_tvalid || m_axis_tdata !== sd || m_axis_tdest !== sdst || m_axis_tlast !== sl))
      unstable = unstable + 1;
    stall_q = m_axis_tvalid && !m_axis_tready;
    sd = m_axis_tdata;
    sdst = m_axis_tdest;
    sl = m_axis_tlast;
    if (hdr_err) errs = errs + 1;
    if (hdr_err && busy) coinc = coinc + 1;
    if (m_axis_tvalid && s_axis_tready) overlap = overlap + 1;
    if (s_axis_tvalid && s_axis_tready) beats = beats + 1;
    if (busy) busy_seen = busy_seen + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (tog) m_axis_tready = ~m_axis_tready;
  endtask

  task automatic send_beat(input logic [31:0] d);
    int n;
    s_axis_tdata = d;
    s_axis_tvalid = 1'b1;
    n = 0;
    while (!s_axis_tready && n < 100) begin
      tick();
      n++;
    end
    total_cnt++;
    if (!s_axis_tready) $display("FAIL beat_accept: tready=%0b after %0d cycles, required 1", s_axis_tready, n);
    else pass_cnt++;
    tick();
  endtask

  task automatic wait_words(input int target);
    int n;
    n = 0;
    while (widx < target && n < 80) begin
      tick();
      n++;
    end
    total_cnt++;
    if (widx < target) $display("FAIL word_timeout: got %0d words, required %0d", widx, target);
    else pass_cnt++;
  endtask

  task automatic run_t1(input string tag);
    logic [255:0] e;
    int base;
    base = widx;
    send_beat(32'hA530_0001);
    for (int i = 0; i < 8; i++) begin
      send_beat(32'h1000_0000 + i);
      e[i*32 +: 32] = 32'h1000_0000 + i;
    end
    s_axis_tvalid = 1'b0;
    wait_words(base + 1);
    tick();
    tick();
    total_cnt++;
    if (widx !== base + 1) $display("FAIL %s_count: got %0d words, required %0d", tag, widx - base, 1);
    else pass_cnt++;
    rd = base;
    total_cnt++;
    if (wd[rd] !== e) $display("FAIL %s_data: got %h required %h", tag, wd[rd], e);
    else pass_cnt++;
    total_cnt++;
    if (wd[rd][31:0] !== 32'h1000_0000 || wd[rd][255:224] !== 32'h1000_0007)
      $display("FAIL %s_lanes: got lo %h hi %h, required 10000000 10000007", tag, wd[rd][31:0], wd[rd][255:224]);
    else pass_cnt++;
    total_cnt++;
    if (wdst[rd] !== 4'd3 || wl[rd] !== 1'b1) $display("FAIL %s_tag: got dest %0d last %0b, required 3 1", tag, wdst[rd], wl[rd]);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL %s_busy: got %0b, required 0", tag, busy);
    else pass_cnt++;
    rd = widx;
  endtask

  task automatic test_reset();
    #2;
    total_cnt++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdest, m_axis_tdata, busy, hdr_err} !== '0)
      $display("FAIL reset_outputs: got tvalid %0b tlast %0b tdest %0d tdata %h busy %0b hdr_err %0b, required all 0",
               m_axis_tvalid, m_axis_tlast, m_axis_tdest, m_axis_tdata, busy, hdr_err);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    total_cnt++;
    if (s_axis_tready !== 1'b1) $display("FAIL idle_tready: got %0b, required 1", s_axis_tready);
    else pass_cnt++;
  endtask

  task automatic test_single();
    run_t1("single");
  endtask

  task automatic test_stall();
    int base, ov0, un0;
    logic [255:0] e;
    base = widx;
    ov0 = overlap;
    un0 = unstable;
    m_axis_tready = 1'b1;
    tog = 1'b1;
    send_beat(32'hA5F0_0003);
    for (int i = 0; i < 24; i++) send_beat(32'h2000_0000 + i);
    s_axis_tvalid = 1'b0;
    wait_words(base + 3);
    tog = 1'b0;
    m_axis_tready = 1'b1;
    tick();
    tick();
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 8; k++) e[k*32 +: 32] = 32'h2000_0000 + 8*w + k;
      total_cnt++;
      if (wd[base+w] !== e) $display("FAIL stall_data%0d: got %h required %h", w, wd[base+w], e);
      else pass_cnt++;
      total_cnt++;
      if (wdst[base+w] !== 4'd15 || wl[base+w] !== (w == 2))
        $display("FAIL stall_tag%0d: got dest %0d last %0b, required 15 %0b", w, wdst[base+w], wl[base+w], w == 2);
      else pass_cnt++;
    end
    total_cnt++;
    if (unstable - un0 !== 0) $display("FAIL stall_stable: got %0d unstable cycles, required 0", unstable - un0);
    else pass_cnt++;
    total_cnt++;
    if (overlap - ov0 !== 0) $display("FAIL stall_no_overlap: got %0d cycles tready in SEND, required 0", overlap - ov0);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0 || widx !== base + 3) $display("FAIL stall_end: got busy %0b words %0d, required 0 3", busy, widx - base);
    else pass_cnt++;
    rd = widx;
  endtask

  task automatic test_bad_hdr();
    int base, e0, b0;
    base = widx;
    e0 = errs;
    b0 = busy_seen;
    send_beat(32'h5A00_0001);
    send_beat(32'hA501_0001);
    send_beat(32'hA500_0000);
    s_axis_tvalid = 1'b0;
    tick();
    tick();
    total_cnt++;
    if (errs - e0 !== 3) $display("FAIL bad_hdr_pulses: got %0d, required 3", errs - e0);
    else pass_cnt++;
    total_cnt++;
    if (widx !== base || busy_seen - b0 !== 0) $display("FAIL bad_hdr_quiet: got words %0d busy cycles %0d, required 0 0", widx - base, busy_seen - b0);
    else pass_cnt++;
    total_cnt++;
    if (coinc !== 0) $display("FAIL hdr_err_busy: got %0d coincidences, required 0", coinc);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    send_beat(32'hA520_0002);
    for (int i = 0; i < 5; i++) send_beat(32'hDEAD_0000 + i);
    s_axis_tvalid = 1'b0;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL mid_busy: got %0b, required 1", busy);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdest, m_axis_tdata, busy, hdr_err} !== '0)
      $display("FAIL mid_reset_outputs: got tvalid %0b tdest %0d tdata %h busy %0b, required all 0",
               m_axis_tvalid, m_axis_tdest, m_axis_tdata, busy);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    tick();
    run_t1("after_reset");
  endtask

  task automatic test_gaps();
    int base, b0;
    logic [31:0] bv [0:31];
    logic [255:0] e;
    base = widx;
    b0 = beats;
    for (int i = 0; i < 32; i++) bv[i] = 32'h7000_0000 + i * 32'h0001_0003;
    send_beat(32'hA570_0004);
    for (int i = 0; i < 32; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        s_axis_tvalid = 1'b0;
        tick();
      end
      send_beat(bv[i]);
    end
    s_axis_tvalid = 1'b0;
    wait_words(base + 4);
    tick();
    tick();
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 8; k++) e[k*32 +: 32] = bv[8*w+k];
      total_cnt++;
      if (wd[base+w] !== e || wdst[base+w] !== 4'd7 || wl[base+w] !== (w == 3))
        $display("FAIL gaps_word%0d: got %h dest %0d last %0b, required %h 7 %0b", w, wd[base+w], wdst[base+w], wl[base+w], e, w == 3);
      else pass_cnt++;
    end
    total_cnt++;
    if (beats - b0 - 1 !== 32) $display("FAIL gaps_beats: got %0d payload beats, required 32", beats - b0 - 1);
    else pass_cnt++;
    rd = widx;
  endtask

  task automatic test_hdr_payload();
    int base, e0;
    base = widx;
    e0 = errs;
    send_beat(32'hA500_0001);
    for (int i = 0; i < 8; i++) send_beat(32'hA530_0001);
    s_axis_tvalid = 1'b0;
    wait_words(base + 1);
    tick();
    total_cnt++;
    if (wd[base] !== {8{32'hA530_0001}} || wdst[base] !== 4'd0 || wl[base] !== 1'b1)
      $display("FAIL hdr_payload: got %h dest %0d last %0b, required %h 0 1", wd[base], wdst[base], wl[base], {8{32'hA530_0001}});
    else pass_cnt++;
    total_cnt++;
    if (errs - e0 !== 0) $display("FAIL hdr_payload_err: got %0d pulses, required 0", errs - e0);
    else pass_cnt++;
  endtask

  initial begin
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    test_reset();
    test_single();
    test_stall();
    test_bad_hdr();
    test_reset_mid();
    test_gaps();
    test_hdr_payload();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
